// File: rtl/onehot_select_seq.sv
// ---------------------------------------------------------------------------
// onehot_select_seq
//   Registered index sequencer driving a one-hot select bus. The index can be
//   loaded, stepped (scanned), held or cleared. Loads are range checked
//   against NUM_OUT, and the last-index behaviour of a step is chosen by
//   `wrap`. Used for register-file write-enable generation and for
//   sequential scans of memory-mapped slots.
//
//   Parameters
//     ADDR_W   width of addr / index
//     NUM_OUT  number of select outputs, 2 .. 2**ADDR_W (need not be pow2)
//
//   Ports
//     clk      rising-edge clock
//     rst_n    asynchronous active-low reset
//     en       command enable; mode is ignored while low
//     mode     00 HOLD, 01 LOAD, 10 STEP, 11 CLEAR
//     addr     index for LOAD
//     wrap     STEP at last index: 1 = wrap to 0, 0 = end the scan
//     sel      one-hot select of index while valid, else all zero
//     valid    an index is active
//     index    current index register
//     err      sticky out-of-range LOAD flag
//     done     one-cycle pulse when a scan ends or wraps
// ---------------------------------------------------------------------------

// One select lane: compares the registered index against its own position.
// It depends on registered state only, so sel has no input-to-output path.
module onehot_select_lane #(
    parameter int ADDR_W = 4,
    parameter int LANE   = 0
) (
    input  logic [ADDR_W-1:0] index,
    input  logic              valid,
    output logic              sel
);
    localparam logic [ADDR_W-1:0] LANE_IDX = ADDR_W'(LANE);

    assign sel = valid && (index == LANE_IDX);
endmodule

module onehot_select_seq #(
    parameter int ADDR_W  = 4,
    parameter int NUM_OUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [ADDR_W-1:0]  addr,
    input  logic               wrap,
    output logic [NUM_OUT-1:0] sel,
    output logic               valid,
    output logic [ADDR_W-1:0]  index,
    output logic               err,
    output logic               done
);
    typedef enum logic [1:0] {
        CMD_HOLD  = 2'b00,
        CMD_LOAD  = 2'b01,
        CMD_STEP  = 2'b10,
        CMD_CLEAR = 2'b11
    } cmd_e;

    // One extra bit so NUM_OUT == 2**ADDR_W is representable in the compare.
    localparam logic [ADDR_W:0]   NUM_OUT_EXT = (ADDR_W+1)'(NUM_OUT);
    localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(NUM_OUT - 1);

    logic [ADDR_W-1:0] index_q, index_d;
    logic              valid_q, valid_d;
    logic              err_q,   err_d;
    logic              done_q,  done_d;
    // Low for the first edge after reset release, so the command present
    // while rst_n deasserts is never executed.
    logic              run_q,   run_d;

    logic              addr_ok;
    cmd_e              cmd;

    assign addr_ok = ({1'b0, addr} < NUM_OUT_EXT);
    assign cmd     = cmd_e'(mode);
    assign run_d   = 1'b1;

    always_comb begin
        index_d = index_q;
        valid_d = valid_q;
        err_d   = err_q;
        done_d  = 1'b0;
        if (run_q && en) begin
            case (cmd)
                CMD_HOLD: ;
                CMD_LOAD: begin
                    if (addr_ok) begin
                        index_d = addr;
                        valid_d = 1'b1;
                        err_d   = 1'b0;
                    end else begin
                        // Index is kept, only validity drops.
                        valid_d = 1'b0;
                        err_d   = 1'b1;
                    end
                end
                CMD_STEP: begin
                    if (valid_q) begin
                        // Explicit end compare: NUM_OUT need not be a
                        // power of two, so counter overflow is not used.
                        if (index_q == LAST_IDX) begin
                            done_d = 1'b1;
                            if (wrap) index_d = '0;
                            else      valid_d = 1'b0;
                        end else begin
                            index_d = index_q + ADDR_W'(1);
                        end
                    end
                end
                CMD_CLEAR: begin
                    index_d = '0;
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            index_q <= index_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            done_q  <= done_d;
            run_q   <= run_d;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_OUT; g++) begin : g_lane
            onehot_select_lane #(
                .ADDR_W (ADDR_W),
                .LANE   (g)
            ) u_lane (
                .index (index_q),
                .valid (valid_q),
                .sel   (sel[g])
            );
        end
    endgenerate

    assign valid = valid_q;
    assign index = index_q;
    assign err   = err_q;
    assign done  = done_q;
endmodule

// File: tb/tb_onehot_select_seq.sv
module tb_onehot_select_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [3:0]  addr = 4'd0;
    logic        wrap = 1'b0;

    logic [15:0] sel16;
    logic        valid16, err16, done16;
    logic [3:0]  index16;
    logic [9:0]  sel10;
    logic        valid10, err10, done10;
    logic [3:0]  index10;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    onehot_select_seq #(.ADDR_W(4), .NUM_OUT(16)) u16 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .addr(addr), .wrap(wrap),
        .sel(sel16), .valid(valid16), .index(index16), .err(err16), .done(done16));

    onehot_select_seq #(.ADDR_W(4), .NUM_OUT(10)) u10 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .addr(addr), .wrap(wrap),
        .sel(sel10), .valid(valid10), .index(index10), .err(err10), .done(done10));

    localparam logic [1:0] HOLD = 2'b00, LOAD = 2'b01, STEP = 2'b10, CLR = 2'b11;

    typedef struct {
        bit          d10;   // 1: check the NUM_OUT=10 instance
        logic        en;
        logic [1:0]  mode;
        logic [3:0]  addr;
        logic        wrap;
        logic [15:0] sel;
        logic        valid;
        logic [3:0]  index;
        logic        err;
        logic        done;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit d10, logic e, logic [1:0] m, logic [3:0] a, logic w,
                                logic [15:0] s, logic v, logic [3:0] i, logic er,
                                logic dn, string n);
        vec_t r;
        r.d10 = d10; r.en = e; r.mode = m; r.addr = a; r.wrap = w;
        r.sel = s; r.valid = v; r.index = i; r.err = er; r.done = dn; r.name = n;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(bit d10, string name, logic [15:0] s, logic v,
                           logic [3:0] i, logic er, logic dn);
        if (d10) begin
            chk({name, ".sel"},   {22'd0, sel10}, {16'd0, s});
            chk({name, ".valid"}, 32'(valid10), 32'(v));
            chk({name, ".index"}, 32'(index10), 32'(i));
            chk({name, ".err"},   32'(err10), 32'(er));
            chk({name, ".done"},  32'(done10), 32'(dn));
        end else begin
            chk({name, ".sel"},   {16'd0, sel16}, {16'd0, s});
            chk({name, ".valid"}, 32'(valid16), 32'(v));
            chk({name, ".index"}, 32'(index16), 32'(i));
            chk({name, ".err"},   32'(err16), 32'(er));
            chk({name, ".done"},  32'(done16), 32'(dn));
        end
    endtask

    // Inputs are changed 1 time unit after a rising edge; outputs sampled
    // 1 time unit after the next one.
    task automatic cmd(logic e, logic [1:0] m, logic [3:0] a, logic w);
        en = e; mode = m; addr = a; wrap = w;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // --- NUM_OUT = 16 ---
        vecs.push_back(mk(0, 1, HOLD, 0, 0, 16'h0000, 0, 0, 0, 0, "idle1"));
        vecs.push_back(mk(0, 1, HOLD, 0, 0, 16'h0000, 0, 0, 0, 0, "idle2"));
        vecs.push_back(mk(0, 1, HOLD, 0, 0, 16'h0000, 0, 0, 0, 0, "idle3"));
        vecs.push_back(mk(0, 1, LOAD, 5, 0, 16'h0020, 1, 5, 0, 0, "load5"));
        vecs.push_back(mk(0, 0, LOAD, 9, 0, 16'h0020, 1, 5, 0, 0, "en0"));
        vecs.push_back(mk(0, 1, LOAD, 14, 0, 16'h4000, 1, 14, 0, 0, "load14"));
        vecs.push_back(mk(0, 1, STEP, 0, 1, 16'h8000, 1, 15, 0, 0, "step15"));
        vecs.push_back(mk(0, 1, STEP, 0, 1, 16'h0001, 1, 0, 0, 1, "wrap0"));
        vecs.push_back(mk(0, 1, STEP, 0, 1, 16'h0002, 1, 1, 0, 0, "step1"));
        vecs.push_back(mk(0, 1, HOLD, 0, 1, 16'h0002, 1, 1, 0, 0, "hold1"));
        vecs.push_back(mk(0, 1, CLR, 0, 0, 16'h0000, 0, 0, 0, 0, "clr16"));
        vecs.push_back(mk(0, 1, LOAD, 15, 0, 16'h8000, 1, 15, 0, 0, "load15ok"));
        // --- NUM_OUT = 10 ---
        vecs.push_back(mk(1, 1, LOAD, 8, 0, 16'h0100, 1, 8, 0, 0, "t10load8"));
        vecs.push_back(mk(1, 1, STEP, 0, 0, 16'h0200, 1, 9, 0, 0, "t10step9"));
        vecs.push_back(mk(1, 1, STEP, 0, 0, 16'h0000, 0, 9, 0, 1, "t10end"));
        vecs.push_back(mk(1, 1, STEP, 0, 0, 16'h0000, 0, 9, 0, 0, "t10after"));
        vecs.push_back(mk(1, 1, LOAD, 3, 0, 16'h0008, 1, 3, 0, 0, "t10load3"));
        vecs.push_back(mk(1, 1, LOAD, 12, 0, 16'h0000, 0, 3, 1, 0, "t10oor12"));
        vecs.push_back(mk(1, 1, STEP, 0, 1, 16'h0000, 0, 3, 1, 0, "t10stepinv"));
        vecs.push_back(mk(1, 1, HOLD, 0, 0, 16'h0000, 0, 3, 1, 0, "t10sticky"));
        vecs.push_back(mk(1, 1, LOAD, 2, 0, 16'h0004, 1, 2, 0, 0, "t10load2"));
        vecs.push_back(mk(1, 1, LOAD, 15, 0, 16'h0000, 0, 2, 1, 0, "t10oor15"));
        vecs.push_back(mk(1, 1, CLR, 0, 0, 16'h0000, 0, 0, 0, 0, "t10clr"));
        vecs.push_back(mk(1, 1, LOAD, 10, 0, 16'h0000, 0, 0, 1, 0, "t10oor10"));
        vecs.push_back(mk(1, 1, LOAD, 9, 0, 16'h0200, 1, 9, 0, 0, "t10load9"));
        vecs.push_back(mk(1, 1, STEP, 0, 1, 16'h0001, 1, 0, 0, 1, "t10wrap"));

        // Asynchronous reset assertion between edges.
        #2 rst_n = 1'b0;
        #1;
        chk_all(0, "rst16", 16'h0, 0, 0, 0, 0);
        chk_all(1, "rst10", 16'h0, 0, 0, 0, 0);
        @(posedge clk);
        #7 rst_n = 1'b1;          // released between edges, HOLD applied
        @(posedge clk);
        #1;

        foreach (vecs[k]) begin
            cmd(vecs[k].en, vecs[k].mode, vecs[k].addr, vecs[k].wrap);
            chk_all(vecs[k].d10, vecs[k].name, vecs[k].sel, vecs[k].valid,
                    vecs[k].index, vecs[k].err, vecs[k].done);
        end

        // Reset mid-scan, no clock edge needed.
        cmd(1, LOAD, 6, 1);
        cmd(1, STEP, 0, 1);
        chk_all(0, "scan7", 16'h0080, 1, 7, 0, 0);
        #3 rst_n = 1'b0;
        #1;
        chk_all(0, "midrst", 16'h0, 0, 0, 0, 0);
        // Command present while reset is released is not executed.
        en = 1'b1; mode = LOAD; addr = 4'd7; wrap = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all(0, "relign", 16'h0, 0, 0, 0, 0);
        cmd(1, LOAD, 7, 0);
        chk_all(0, "reload7", 16'h0080, 1, 7, 0, 0);
        cmd(1, STEP, 0, 0);
        chk_all(0, "resume8", 16'h0100, 1, 8, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety bound on total run time.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
